rt_rgu_stream: RTL and testbench
================================

Name: rt_rgu_stream

Overview:
- Parametrised, streaming successor to the single-ray RGU.
- A frame_start pulse snapshots the camera parameters and the frame size. An internal raster scanner then generates every pixel coordinate (x, y).
- Each coordinate passes through a 4-stage arithmetic pipeline: scale, offset, centre, subtract. One ray per cycle leaves on a ready/valid stream with backpressure, feeding the intersection units.

Parameters:
- IW, 16, integer bits of the signed fixed-point format.
- QW, 16, fractional bits; word length WL = IW+QW.
- CW, 12, width of the pixel-coordinate counters and the frame width/height inputs.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle request to start a frame
- frame_width  in  CW  pixels per row, sampled on an accepted frame_start
- frame_height  in  CW  rows, sampled on an accepted frame_start
- pixel_00_loc  in  3xWL  signed fixed point, sampled on an accepted frame_start
- pixel_delta_u  in  3xWL  sampled on an accepted frame_start
- pixel_delta_v  in  3xWL  sampled on an accepted frame_start
- camera_center  in  3xWL  sampled on an accepted frame_start
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame
- out_valid  out  1  ray beat valid
- out_ready  in  1  downstream accepts the beat
- out_x  out  CW  pixel column of the beat
- out_y  out  CW  pixel row of the beat
- out_last  out  1  final pixel of the frame
- ray_origin  out  3xWL  latched camera_center
- ray_direction  out  3xWL  computed direction

Behaviour:
- Reset (async, active-high): every pipeline valid bit, counter and output is 0; busy=0, frame_done=0, out_valid=0. A reset mid-frame abandons the frame without a frame_done pulse.
- Frame_start is accepted only when busy=0; while busy=1 it is ignored.
  - On the accepting edge: camera parameters and size are snapshotted into shadow registers.
  - If width≠0 and height≠0: busy←1 and stage S0 is loaded with (0,0) valid.
  - If width=0 or height=0: no beats are produced, busy stays 0, and frame_done pulses on the next cycle.
- Scanner (S0) order is raster, x fastest. After x=W-1 it wraps to x=0 and y increments. After (W-1,H-1) it stops issuing.
  - S0 carries a last flag, set for (W-1,H-1).
- Pipeline stages:
  - S1: px = du*x and py = dv*y, where x and y are the integer coordinates promoted to fixed point (value<<QW, zero-extended).
  - S2: off = px+py.
  - S3: ctr = pixel_00_loc+off.
  - S4 (output register): dir = ctr−camera_center.
  - Each stage carries valid, x, y and last alongside the data.
- Arithmetic:
  - Products are formed full-width at 2·WL and truncated to bits [QW+WL-1:QW].
  - Adds and subtracts wrap modulo 2^WL.
  - ray_origin is the snapshot camera_center, constant for the whole frame.
- Handshake and stall:
  - adv = !out_valid | out_ready. The whole pipeline and the scanner advance only when adv=1; otherwise every stage holds.
  - A transfer occurs on an edge where out_valid & out_ready.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - Bubbles are not collapsed. With the stream free-flowing there are no bubbles inside a frame.
- Latency: the first beat has out_valid=1 after the 4th rising edge following the accepting edge. Throughput is 1 beat/cycle when out_ready=1. A frame with no stalls takes W·H+4 cycles from accept to the last handshake.
- End of frame: on the handshake of the out_last beat, busy←0 and frame_done=1 for exactly the next cycle.
  - A frame_start arriving in that frame_done cycle is accepted (busy=0).
- Input changes: changes to the camera inputs during a frame have no effect on the frame in progress.

Optional Feature:
- Macro: RGU_SATURATE_EN.
- Defined: truncated products, sums and differences saturate to 0x7FF…F or 0x800…0 on overflow.
  - For products, overflow means the discarded upper bits are not a sign extension.
  - A sticky overflow output port (1 bit) is added. It is cleared on an accepted frame_start and set on any saturation event.
- Undefined: plain wrap/truncate arithmetic and no overflow port.

Test Plan:
- QW=16, W=2, H=2, du=(1.0,0,0), dv=(0,−1.0,0), p00=(0.5,0.5,−1.0), cc=0, out_ready=1 → beats in order (0,0),(1,0),(0,1),(1,1); dir of the last beat = (1.5,−0.5,−1.0); out_last only on the 4th beat; first valid 4 edges after accept; frame_done pulses once after the last handshake.
- Same frame, out_ready driven 1,0,0,1,0,1… → no beat lost or duplicated; outputs held stable on every cycle with out_valid=1 and out_ready=0.
- frame_start with W=0, H=5 → no out_valid, busy stays 0, frame_done pulses one cycle later.
- frame_start again while busy, with camera inputs altered mid-frame → second request ignored; all rays use the first snapshot.
- Assert reset in the middle of a 4x4 frame → out_valid, busy and frame_done drop to 0 asynchronously; a new frame afterwards starts cleanly at (0,0).
- RGU_SATURATE_EN defined, du.x=0x7FFF0000 (max ≈32767.0), x=3 → dir.x saturates to 0x7FFFFFFF and overflow=1. Undefined: the same stimulus wraps.

Source files
------------

// File: rtl/rt_rgu_stream.sv
// rt_rgu_stream: streaming ray generation unit.
// A frame_start (accepted only while idle) snapshots the camera and the frame
// size. A raster scanner then walks every pixel (x fastest). Each pixel runs
// through a 4-stage pipeline (scale, offset, centre, subtract) and leaves as
// one ray per cycle on a ready/valid stream with backpressure.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   frame_start           request a frame (ignored while busy)
//   frame_width/height    frame size in pixels, sampled on accept
//   pixel_00_loc          3xWL fixed point, index 0=x 1=y 2=z, sampled on accept
//   pixel_delta_u/v       3xWL per-pixel steps, sampled on accept
//   camera_center         3xWL, sampled on accept
//   busy                  frame in progress
//   frame_done            one-cycle pulse at end of frame
//   out_valid/out_ready   output stream handshake
//   out_x/out_y/out_last  pixel coordinate of the beat, last-pixel flag
//   ray_origin            snapshot camera_center
//   ray_direction         pixel_00_loc + du*x + dv*y - camera_center
//   overflow              sticky saturation flag (RGU_SATURATE_EN builds only)
//
// Optional feature: define RGU_SATURATE_EN to saturate products, sums and
// differences instead of wrapping, and to add the overflow port.
module rt_rgu_stream #(
  parameter int unsigned IW = 16,
  parameter int unsigned QW = 16,
  parameter int unsigned CW = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [CW-1:0]         frame_width,
  input  logic [CW-1:0]         frame_height,
  input  logic [2:0][IW+QW-1:0] pixel_00_loc,
  input  logic [2:0][IW+QW-1:0] pixel_delta_u,
  input  logic [2:0][IW+QW-1:0] pixel_delta_v,
  input  logic [2:0][IW+QW-1:0] camera_center,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_x,
  output logic [CW-1:0]         out_y,
  output logic                  out_last,
  output logic [2:0][IW+QW-1:0] ray_origin,
  output logic [2:0][IW+QW-1:0] ray_direction
`ifdef RGU_SATURATE_EN
  ,
  output logic                  overflow
`endif
);

  localparam int unsigned WL = IW + QW;
  typedef logic [2:0][WL-1:0] vec3_t;

`ifdef RGU_SATURATE_EN
  localparam logic [WL-1:0] FX_MAX = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] FX_MIN = {1'b1, {(WL-1){1'b0}}};
`endif

  // Full 2*WL product of a signed word and an integer coordinate promoted to fixed point
  function automatic logic [2*WL-1:0] mul_full(input logic [WL-1:0] a, input logic [CW-1:0] c);
    logic [WL-1:0] cf;
    cf = WL'(c) << QW;
    return {{WL{a[WL-1]}}, a} * {{WL{1'b0}}, cf};
  endfunction

`ifdef RGU_SATURATE_EN
  // Product overflows when the bits above the kept window are not a sign extension
  function automatic logic mul_ovf(input logic [2*WL-1:0] full);
    logic [2*WL-1:0] hi;
    hi = $signed(full) >>> (QW + WL - 1);
    return (hi != '0) && (hi != '1);
  endfunction

  function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sd);
    return (sa != sb) && (sd != sa);
  endfunction
`endif

  function automatic logic [WL-1:0] fx_mul(input logic [WL-1:0] a, input logic [CW-1:0] c);
    logic [2*WL-1:0] full;
    full = mul_full(a, c);
`ifdef RGU_SATURATE_EN
    if (mul_ovf(full)) return full[2*WL-1] ? FX_MIN : FX_MAX;
`endif
    return WL'(full >> QW);
  endfunction

  function automatic logic [WL-1:0] fx_add(input logic [WL-1:0] a, input logic [WL-1:0] b);
    logic [WL-1:0] s;
    s = a + b;
`ifdef RGU_SATURATE_EN
    if (add_ovf(a[WL-1], b[WL-1], s[WL-1])) return a[WL-1] ? FX_MIN : FX_MAX;
`endif
    return s;
  endfunction

  function automatic logic [WL-1:0] fx_sub(input logic [WL-1:0] a, input logic [WL-1:0] b);
    logic [WL-1:0] d;
    d = a - b;
`ifdef RGU_SATURATE_EN
    if (sub_ovf(a[WL-1], b[WL-1], d[WL-1])) return a[WL-1] ? FX_MIN : FX_MAX;
`endif
    return d;
  endfunction

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic          accept_c, done_d, size_zero_c, adv_c;

  logic [CW-1:0] sh_w, sh_h;
  vec3_t         sh_p00, sh_du, sh_dv;

  logic          s0_valid, s0_last;
  logic [CW-1:0] s0_x, s0_y;
  logic [CW-1:0] nx_x, nx_y;
  logic          nx_last;

  logic          s1_valid, s1_last, s2_valid, s2_last, s3_valid, s3_last;
  logic [CW-1:0] s1_x, s1_y, s2_x, s2_y, s3_x, s3_y;
  vec3_t         px, py, off, ctr;

  assign size_zero_c = (frame_width == '0) || (frame_height == '0);
  assign adv_c       = !out_valid || out_ready;
  assign busy        = (state_q == ST_RUN);

  // Frame control state register
  always_ff @(posedge clk or posedge reset) begin : fsm_reg
    if (reset) begin
      state_q    <= ST_IDLE;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= done_d;
    end
  end

  // Frame control next state: accept while idle, finish on the last handshake
  always_comb begin : fsm_next
    state_d  = state_q;
    accept_c = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          accept_c = 1'b1;
          if (size_zero_c) done_d = 1'b1;
          else             state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (out_valid && out_ready && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Camera and frame-size snapshot
  always_ff @(posedge clk or posedge reset) begin : shadow_reg
    if (reset) begin
      sh_w       <= '0;
      sh_h       <= '0;
      sh_p00     <= '0;
      sh_du      <= '0;
      sh_dv      <= '0;
      ray_origin <= '0;
    end else if (accept_c) begin
      sh_w       <= frame_width;
      sh_h       <= frame_height;
      sh_p00     <= pixel_00_loc;
      sh_du      <= pixel_delta_u;
      sh_dv      <= pixel_delta_v;
      ray_origin <= camera_center;
    end
  end

  // Raster successor of the current scanner coordinate
  always_comb begin : scan_next
    nx_x = s0_x + CW'(1);
    nx_y = s0_y;
    if (s0_x == sh_w - CW'(1)) begin
      nx_x = '0;
      nx_y = s0_y + CW'(1);
    end
    nx_last = (nx_x == sh_w - CW'(1)) && (nx_y == sh_h - CW'(1));
  end

  // Scanner and arithmetic pipeline; every stage holds while the output is stalled
  always_ff @(posedge clk or posedge reset) begin : pipe_reg
    if (reset) begin
      s0_valid <= 1'b0; s0_last <= 1'b0; s0_x <= '0; s0_y <= '0;
      s1_valid <= 1'b0; s1_last <= 1'b0; s1_x <= '0; s1_y <= '0;
      s2_valid <= 1'b0; s2_last <= 1'b0; s2_x <= '0; s2_y <= '0;
      s3_valid <= 1'b0; s3_last <= 1'b0; s3_x <= '0; s3_y <= '0;
      px <= '0; py <= '0; off <= '0; ctr <= '0;
      out_valid <= 1'b0; out_last <= 1'b0; out_x <= '0; out_y <= '0;
      ray_direction <= '0;
    end else begin
      if (accept_c) begin
        s0_valid <= !size_zero_c;
        s0_x     <= '0;
        s0_y     <= '0;
        s0_last  <= (frame_width == CW'(1)) && (frame_height == CW'(1));
      end else if (adv_c && s0_valid) begin
        if (s0_last) begin
          s0_valid <= 1'b0;
        end else begin
          s0_x    <= nx_x;
          s0_y    <= nx_y;
          s0_last <= nx_last;
        end
      end
      if (adv_c) begin
        s1_valid  <= s0_valid; s1_last <= s0_last; s1_x <= s0_x; s1_y <= s0_y;
        s2_valid  <= s1_valid; s2_last <= s1_last; s2_x <= s1_x; s2_y <= s1_y;
        s3_valid  <= s2_valid; s3_last <= s2_last; s3_x <= s2_x; s3_y <= s2_y;
        out_valid <= s3_valid; out_last <= s3_last; out_x <= s3_x; out_y <= s3_y;
        for (int k = 0; k < 3; k++) begin
          px[k]            <= fx_mul(sh_du[k], s0_x);
          py[k]            <= fx_mul(sh_dv[k], s0_y);
          off[k]           <= fx_add(px[k], py[k]);
          ctr[k]           <= fx_add(sh_p00[k], off[k]);
          ray_direction[k] <= fx_sub(ctr[k], ray_origin[k]);
        end
      end
    end
  end

`ifdef RGU_SATURATE_EN
  logic ovf_evt_c;

  // Any stage holding valid data that saturates on this advance
  always_comb begin : ovf_detect
    logic [WL-1:0] t_off, t_ctr, t_dir;
    ovf_evt_c = 1'b0;
    t_off = '0;
    t_ctr = '0;
    t_dir = '0;
    for (int k = 0; k < 3; k++) begin
      t_off = px[k] + py[k];
      t_ctr = sh_p00[k] + off[k];
      t_dir = ctr[k] - ray_origin[k];
      ovf_evt_c = ovf_evt_c
        | (s0_valid & (mul_ovf(mul_full(sh_du[k], s0_x)) | mul_ovf(mul_full(sh_dv[k], s0_y))))
        | (s1_valid & add_ovf(px[k][WL-1], py[k][WL-1], t_off[WL-1]))
        | (s2_valid & add_ovf(sh_p00[k][WL-1], off[k][WL-1], t_ctr[WL-1]))
        | (s3_valid & sub_ovf(ctr[k][WL-1], ray_origin[k][WL-1], t_dir[WL-1]));
    end
  end

  // Sticky overflow, cleared when a new frame is accepted
  always_ff @(posedge clk or posedge reset) begin : ovf_reg
    if (reset)                    overflow <= 1'b0;
    else if (accept_c)            overflow <= 1'b0;
    else if (adv_c && ovf_evt_c)  overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_rt_rgu_stream.sv
// Bench for rt_rgu_stream: directed frames checked against an integer-arithmetic
// reference model (expected beat queue) by a per-cycle monitor, plus literal checks.
module tb_rt_rgu_stream;
  localparam int unsigned IW = 16;
  localparam int unsigned QW = 16;
  localparam int unsigned CW = 12;
  localparam int unsigned WL = IW + QW;

  typedef logic [2:0][WL-1:0] vec3_t;
  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;
    vec3_t         dir;
    vec3_t         org;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, fs, out_ready;
  logic [CW-1:0] fw, fh;
  vec3_t         p00, du, dv, cc;
  logic          busy, frame_done, out_valid, out_last;
  logic [CW-1:0] out_x, out_y;
  vec3_t         ray_origin, ray_direction;
`ifdef RGU_SATURATE_EN
  logic          overflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  beat_t         exp_q[$];
  bit            exp_busy = 1'b0;
  bit            exp_done = 1'b0;
  int            done_count = 0;
  logic [CW-1:0] seen_x[$];
  logic [CW-1:0] seen_y[$];
  logic          seen_last[$];
  vec3_t         seen_dir[$];

  bit            hold = 1'b0;
  logic [CW-1:0] prev_x, prev_y;
  logic          prev_last;
  vec3_t         prev_dir, prev_org;
  logic [5:0]    pat = 6'b101001;

  always #5 clk = ~clk;

  rt_rgu_stream #(.IW(IW), .QW(QW), .CW(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (fs),
    .frame_width   (fw),
    .frame_height  (fh),
    .pixel_00_loc  (p00),
    .pixel_delta_u (du),
    .pixel_delta_v (dv),
    .camera_center (cc),
    .busy          (busy),
    .frame_done    (frame_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_last      (out_last),
    .ray_origin    (ray_origin),
    .ray_direction (ray_direction)
`ifdef RGU_SATURATE_EN
    ,
    .overflow      (overflow)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic longint sx(input logic [WL-1:0] w);
    return longint'($signed(w));
  endfunction

  // Reduce an exact integer result to a WL-bit word (clamp or wrap)
  function automatic logic [WL-1:0] fix(input longint v);
`ifdef RGU_SATURATE_EN
    if (v > 64'sd2147483647)  return {1'b0, {(WL-1){1'b1}}};
    if (v < -64'sd2147483648) return {1'b1, {(WL-1){1'b0}}};
`endif
    return WL'(v);
  endfunction

  // dir = p00 + du*x + dv*y - cc, evaluated in the same order as the datapath
  function automatic logic [WL-1:0] model_dir(input logic [WL-1:0] p, input logic [WL-1:0] u,
                                              input logic [WL-1:0] v, input logic [WL-1:0] c,
                                              input int xx, input int yy);
    logic [WL-1:0] a, b, o, t;
    a = fix(sx(u) * longint'(xx));
    b = fix(sx(v) * longint'(yy));
    o = fix(sx(a) + sx(b));
    t = fix(sx(p) + sx(o));
    return fix(sx(t) - sx(c));
  endfunction

  // Per-cycle monitor: frame control model and beat scoreboard
  always @(negedge clk) begin : monitor
    bit busy_n, done_n;
    if (reset) begin
      exp_q.delete();
      exp_busy = 1'b0;
      exp_done = 1'b0;
      hold     = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
    end else begin
      busy_n = exp_busy;
      done_n = 1'b0;
      chk("busy", busy, exp_busy);
      chk("frame_done", frame_done, exp_done);
      if (frame_done) done_count++;
      if (hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_x", out_x, prev_x);
        chk("hold_y", out_y, prev_y);
        chk("hold_last", out_last, prev_last);
        chk("hold_dir", ray_direction, prev_dir);
        chk("hold_origin", ray_origin, prev_org);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", out_valid, 1'b0);
        end else begin
          chk("beat_x", out_x, exp_q[0].x);
          chk("beat_y", out_y, exp_q[0].y);
          chk("beat_last", out_last, exp_q[0].last);
          chk("beat_dir", ray_direction, exp_q[0].dir);
          chk("beat_origin", ray_origin, exp_q[0].org);
          if (out_ready) begin
            seen_x.push_back(out_x);
            seen_y.push_back(out_y);
            seen_last.push_back(out_last);
            seen_dir.push_back(ray_direction);
            if (exp_q[0].last) begin
              busy_n = 1'b0;
              done_n = 1'b1;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      hold      = out_valid && !out_ready;
      prev_x    = out_x;
      prev_y    = out_y;
      prev_last = out_last;
      prev_dir  = ray_direction;
      prev_org  = ray_origin;
      if (fs && !exp_busy) begin
        if (fw == '0 || fh == '0) begin
          done_n = 1'b1;
        end else begin
          busy_n = 1'b1;
          for (int yy = 0; yy < int'(fh); yy++) begin
            for (int xx = 0; xx < int'(fw); xx++) begin
              beat_t b;
              b.x    = CW'(xx);
              b.y    = CW'(yy);
              b.last = (xx == int'(fw) - 1) && (yy == int'(fh) - 1);
              for (int k = 0; k < 3; k++) b.dir[k] = model_dir(p00[k], du[k], dv[k], cc[k], xx, yy);
              b.org  = cc;
              exp_q.push_back(b);
            end
          end
        end
      end
      exp_busy = busy_n;
      exp_done = done_n;
    end
  end

  // Request one frame and run until frame_done, with optional stall, mid-frame poke or reset
  task automatic run_frame(input int w, input int h, input bit stall, input int poke_at,
                           input int rst_at, output int lat, output int dlen);
    int cnt;
    seen_x.delete();
    seen_y.delete();
    seen_last.delete();
    seen_dir.delete();
    done_count = 0;
    @(posedge clk); #1;
    fs = 1'b1;
    fw = CW'(w);
    fh = CW'(h);
    @(posedge clk); #1;
    fs   = 1'b0;
    cnt  = 0;
    lat  = -1;
    dlen = -1;
    if (frame_done) dlen = 0;
    while (dlen < 0 && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      if (stall) out_ready = pat[cnt % 6];
      if (out_valid && lat < 0) lat = cnt;
      if (frame_done) dlen = cnt;
      if (cnt == poke_at) begin
        fs = 1'b1;
        fw = CW'(7);
        du = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        dv = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        p00 = '0;
        cc  = {32'h1234_0000, 32'h0, 32'h0};
      end
      if (cnt == poke_at + 1) fs = 1'b0;
      if (cnt == rst_at) begin
        reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", frame_done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
    end
    out_ready = 1'b1;
    n_tests++;
    if (dlen < 0) begin
      n_fail++;
      $display("FAIL frame_timeout: got no frame_done expected one within 300 cycles");
    end
  endtask

  initial begin : stim
    int lat, dlen;
    int ex[4] = '{0, 1, 0, 1};
    int ey[4] = '{0, 0, 1, 1};
    logic [WL-1:0] exp_sat;
    reset = 1'b1; fs = 1'b0; out_ready = 1'b1; fw = '0; fh = '0;
    p00 = '0; du = '0; dv = '0; cc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_origin", ray_origin, '0);
    chk("reset_dir", ray_direction, '0);
    reset = 1'b0;

    // 2x2 frame, free flowing
    du  = {32'h0, 32'h0, 32'h0001_0000};
    dv  = {32'h0, 32'hFFFF_0000, 32'h0};
    p00 = {32'hFFFF_0000, 32'h0000_8000, 32'h0000_8000};
    cc  = '0;
    run_frame(2, 2, 1'b0, -10, -1, lat, dlen);
    chk("t1_latency", lat, 4);
    chk("t1_frame_len", dlen, 8);
    chk("t1_beats", seen_x.size(), 4);
    if (seen_x.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_order_x", seen_x[i], CW'(ex[i]));
        chk("t1_order_y", seen_y[i], CW'(ey[i]));
        chk("t1_last_flag", seen_last[i], i == 3);
      end
      chk("t1_last_dir", seen_dir[3], {32'hFFFF_0000, 32'hFFFF_8000, 32'h0001_8000});
    end
    repeat (2) @(posedge clk);
    chk("t1_done_pulses", done_count, 1);
`ifdef RGU_SATURATE_EN
    chk("t1_no_overflow", overflow, 1'b0);
`endif

    // Same frame under backpressure
    run_frame(2, 2, 1'b1, -10, -1, lat, dlen);
    chk("t2_beats", seen_x.size(), 4);
    if (seen_x.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_order_x", seen_x[i], CW'(ex[i]));
        chk("t2_order_y", seen_y[i], CW'(ey[i]));
      end
    end
    repeat (2) @(posedge clk);
    chk("t2_done_pulses", done_count, 1);

    // Zero-width frame
    run_frame(0, 5, 1'b0, -10, -1, lat, dlen);
    chk("t3_done_next_cycle", dlen, 0);
    chk("t3_no_valid", lat, -1);
    chk("t3_not_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    chk("t3_done_pulses", done_count, 1);

    // 3x2 frame, ignored request and camera changes mid-frame
    du  = {32'h0, 32'h0, 32'h0000_4000};
    dv  = {32'h0, 32'h0000_8000, 32'h0};
    p00 = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    cc  = {32'h0, 32'h0000_4000, 32'h0000_8000};
    run_frame(3, 2, 1'b0, 3, -1, lat, dlen);
    chk("t4_frame_len", dlen, 10);
    chk("t4_beats", seen_x.size(), 6);
    if (seen_x.size() == 6)
      chk("t4_last_dir", seen_dir[5], {32'hFFFF_0000, 32'hFFFF_4000, 32'hFFFF_0000});
    repeat (2) @(posedge clk);
    chk("t4_done_pulses", done_count, 1);

    // Reset in the middle of a 4x4 frame, then a clean 4x4 frame
    du  = {32'h0, 32'h0, 32'h0001_0000};
    dv  = {32'h0, 32'h0001_0000, 32'h0};
    p00 = '0;
    cc  = '0;
    run_frame(4, 4, 1'b0, -10, 8, lat, dlen);
    chk("t5_abort_no_done", done_count, 0);
    run_frame(4, 4, 1'b0, -10, -1, lat, dlen);
    chk("t5_latency", lat, 4);
    chk("t5_frame_len", dlen, 20);
    chk("t5_beats", seen_x.size(), 16);
    if (seen_x.size() == 16) begin
      chk("t5_first_x", seen_x[0], '0);
      chk("t5_first_y", seen_y[0], '0);
      chk("t5_last_dir", seen_dir[15], {32'h0, 32'h0003_0000, 32'h0003_0000});
    end
    repeat (2) @(posedge clk);

    // Product overflow at x=3
    du  = {32'h0, 32'h0, 32'h7FFF_0000};
    dv  = '0;
    p00 = '0;
    cc  = '0;
`ifdef RGU_SATURATE_EN
    exp_sat = 32'h7FFF_FFFF;
`else
    exp_sat = 32'h7FFD_0000;
`endif
    run_frame(4, 1, 1'b0, -10, -1, lat, dlen);
    chk("t6_beats", seen_x.size(), 4);
    if (seen_x.size() == 4) begin
      chk("t6_x1_dir", seen_dir[1][0], 32'h7FFF_0000);
      chk("t6_x3_dir", seen_dir[3][0], exp_sat);
    end
`ifdef RGU_SATURATE_EN
    chk("t6_overflow", overflow, 1'b1);
`endif
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
